sdp_be_write_coalescer: RTL

SDP_BE_WRITE_COALESCER -- requirements
Module: sdp_be_write_coalescer

---
 rtl/sdp_be_write_coalescer_pkg.sv | 40 ++++
 rtl/sdp_be_write_coalescer_be_byte_merge.sv | 37 +++
 rtl/sdp_be_write_coalescer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sdp_be_write_coalescer_pkg.sv
// Shared parameters and types for the SDP_be write coalescer.
//
// Holds the default word geometry of the SDP_be memory, the derived data
// width, the timeout counter width, the FSM state type and the write-entry
// struct (addr, data, be) used for the pending entry.
package sdp_be_write_coalescer_pkg;

    localparam int NBYTES_DEF    = 4;
    localparam int BYTEWIDTH_DEF = 8;
    localparam int WABITS_DEF    = 8;
    localparam int WDBITS_DEF    = NBYTES_DEF * BYTEWIDTH_DEF;

    // TIMEOUT is limited to 1..255, so 8 bits always hold the idle count.
    localparam int CNT_W = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } coal_state_t;

    typedef struct packed {
        logic [WABITS_DEF-1:0] addr;
        logic [WDBITS_DEF-1:0] data;
        logic [NBYTES_DEF-1:0] be;
    } wr_entry_t;

    function automatic int wdbits(input int nbytes, input int bytewidth);
        return nbytes * bytewidth;
    endfunction

    // The counter holds the number of completed idle cycles. Write-out is
    // decided on the idle cycle that brings it to TIMEOUT-1, so the decision
    // is taken while the counter still reads TIMEOUT-2 and m_we appears
    // TIMEOUT cycles after the last accepted beat. TIMEOUT=1 fires on the
    // first idle cycle.
    function automatic logic [CNT_W-1:0] timeout_fire_count(input int timeout);
        return (timeout > 1) ? CNT_W'(timeout - 2) : '0;
    endfunction

endpackage

// File: rtl/sdp_be_write_coalescer_be_byte_merge.sv
// be_byte_merge: per-byte priority select of two data/byte-enable pairs.
//
// Ports:
//   hi_data/hi_be   higher-priority word and its byte enables
//   lo_data/lo_be   lower-priority word and its byte enables
//   out_data        per byte: hi if hi_be set, else lo if lo_be set, else 0
//   out_be          hi_be | lo_be
// Bytes enabled by neither side come out as zero, so a merged word is always
// stored masked by its own enables.
module be_byte_merge
    import sdp_be_write_coalescer_pkg::*;
#(
    parameter int NBYTES    = NBYTES_DEF,
    parameter int BYTEWIDTH = BYTEWIDTH_DEF
) (
    input  logic [NBYTES*BYTEWIDTH-1:0] hi_data,
    input  logic [NBYTES-1:0]           hi_be,
    input  logic [NBYTES*BYTEWIDTH-1:0] lo_data,
    input  logic [NBYTES-1:0]           lo_be,
    output logic [NBYTES*BYTEWIDTH-1:0] out_data,
    output logic [NBYTES-1:0]           out_be
);

    always_comb begin
        out_data = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (hi_be[i]) begin
                out_data[i*BYTEWIDTH +: BYTEWIDTH] = hi_data[i*BYTEWIDTH +: BYTEWIDTH];
            end else if (lo_be[i]) begin
                out_data[i*BYTEWIDTH +: BYTEWIDTH] = lo_data[i*BYTEWIDTH +: BYTEWIDTH];
            end
        end
    end

    assign out_be = hi_be | lo_be;

endmodule

// File: rtl/sdp_be_write_coalescer.sv
// sdp_be_write_coalescer: single-entry write coalescer in front of an SDP_be
// BRAM, with read-after-write forwarding.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   s_valid/s_ready                write-beat handshake (s_ready = !flush)
//   s_addr/s_data/s_be             write beat address, data, byte enables
//   flush                          force write-out of the pending entry
//   m_we/m_wa/m_wd/m_be            registered BRAM write port
//   ra -> m_ra                     read address, passed straight through
//   m_rd                           BRAM read data (one cycle after ra)
//   rd                             m_rd with newer pending/in-flight bytes
//   idle                           no pending entry and no write in flight
//
// Beats to the pending address merge byte-wise; a different address, a
// flush or TIMEOUT idle cycles push the entry out to the BRAM. An entry with
// no enabled bytes is dropped instead of written.
// The pending entry uses the package's wr_entry_t, so NBYTES/BYTEWIDTH/WABITS
// are expected to match the package defaults of the SDP_be memory.
module sdp_be_write_coalescer
    import sdp_be_write_coalescer_pkg::*;
#(
    parameter int NBYTES    = NBYTES_DEF,
    parameter int BYTEWIDTH = BYTEWIDTH_DEF,
    parameter int WABITS    = WABITS_DEF,
    parameter int TIMEOUT   = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    input  logic [WABITS-1:0]                      s_addr,
    input  logic [wdbits(NBYTES, BYTEWIDTH)-1:0]   s_data,
    input  logic [NBYTES-1:0]                      s_be,
    input  logic                                   flush,
    output logic                                   m_we,
    output logic [WABITS-1:0]                      m_wa,
    output logic [wdbits(NBYTES, BYTEWIDTH)-1:0]   m_wd,
    output logic [NBYTES-1:0]                      m_be,
    input  logic [WABITS-1:0]                      ra,
    output logic [WABITS-1:0]                      m_ra,
    input  logic [wdbits(NBYTES, BYTEWIDTH)-1:0]   m_rd,
    output logic [wdbits(NBYTES, BYTEWIDTH)-1:0]   rd,
    output logic                                   idle
);

    localparam int WDBITS = wdbits(NBYTES, BYTEWIDTH);
    localparam logic [CNT_W-1:0] FIRE_CNT = timeout_fire_count(TIMEOUT);

    coal_state_t      state;
    wr_entry_t        pend;
    logic [CNT_W-1:0] cnt;

    logic              accept;
    logic              same_addr;
    logic              fire;
    logic              do_wo;
    logic [NBYTES-1:0] merge_lo_be;
    logic [WDBITS-1:0] new_data;
    logic [NBYTES-1:0] new_be;

    logic [NBYTES-1:0] beat_fwd_be;
    logic [NBYTES-1:0] pend_fwd_be;
    logic [NBYTES-1:0] mw_fwd_be;
    logic [WDBITS-1:0] fwd1_data;
    logic [NBYTES-1:0] fwd1_be;
    logic [WDBITS-1:0] fwd_data;
    logic [NBYTES-1:0] fwd_be;
    logic [WDBITS-1:0] snap_data_p1;
    logic [NBYTES-1:0] snap_be_p1;

    assign s_ready = !flush;
    assign m_ra    = ra;
    assign idle    = (state == ST_EMPTY) && !m_we;

    // Beats presented while rst is high never count as accepted.
    assign accept    = s_valid && s_ready && !rst;
    assign same_addr = (s_addr == pend.addr);
    assign fire      = (cnt == FIRE_CNT);

    // A same-address beat wins over an expiring timeout; flush blocks
    // acceptance, so it never competes with a beat.
    assign do_wo = (state == ST_HOLD) &&
                   (flush || (accept && !same_addr) || (!accept && fire));

    // Merge path: with the pending enables zeroed this is a plain masked load.
    assign merge_lo_be = (state == ST_HOLD && same_addr) ? pend.be : '0;

    be_byte_merge #(.NBYTES(NBYTES), .BYTEWIDTH(BYTEWIDTH)) u_merge (
        .hi_data  (s_data),
        .hi_be    (s_be),
        .lo_data  (pend.data),
        .lo_be    (merge_lo_be),
        .out_data (new_data),
        .out_be   (new_be)
    );

    // Forwarding path: accepted beat > pending entry > in-flight BRAM write.
    assign beat_fwd_be = (accept && s_addr == ra)               ? s_be    : '0;
    assign pend_fwd_be = (state == ST_HOLD && pend.addr == ra)  ? pend.be : '0;
    assign mw_fwd_be   = (m_we && m_wa == ra)                   ? m_be    : '0;

    be_byte_merge #(.NBYTES(NBYTES), .BYTEWIDTH(BYTEWIDTH)) u_fwd_hi (
        .hi_data  (s_data),
        .hi_be    (beat_fwd_be),
        .lo_data  (pend.data),
        .lo_be    (pend_fwd_be),
        .out_data (fwd1_data),
        .out_be   (fwd1_be)
    );

    be_byte_merge #(.NBYTES(NBYTES), .BYTEWIDTH(BYTEWIDTH)) u_fwd_lo (
        .hi_data  (fwd1_data),
        .hi_be    (fwd1_be),
        .lo_data  (m_wd),
        .lo_be    (mw_fwd_be),
        .out_data (fwd_data),
        .out_be   (fwd_be)
    );

    // ---- stage p0 -> p1: entry/FSM update, write-out, forwarding snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_EMPTY;
            pend         <= '0;
            cnt          <= '0;
            m_we         <= 1'b0;
            m_wa         <= '0;
            m_wd         <= '0;
            m_be         <= '0;
            snap_data_p1 <= '0;
            snap_be_p1   <= '0;
        end else begin
            // An entry with no enabled bytes is consumed without a BRAM write.
            m_we <= do_wo && (|pend.be);
            if (do_wo) begin
                m_wa <= pend.addr;
                m_wd <= pend.data;
                m_be <= pend.be;
            end

            snap_data_p1 <= fwd_data;
            snap_be_p1   <= fwd_be;

            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        pend  <= '{addr: s_addr, data: new_data, be: new_be};
                        cnt   <= '0;
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (flush) begin
                        cnt   <= '0;
                        state <= ST_EMPTY;
                    end else if (accept) begin
                        pend <= '{addr: s_addr, data: new_data, be: new_be};
                        cnt  <= '0;
                    end else if (fire) begin
                        cnt   <= '0;
                        state <= ST_EMPTY;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    // ---- stage p1: snapshot overlays the BRAM read data
    always_comb begin
        rd = m_rd;
        for (int i = 0; i < NBYTES; i++) begin
            if (snap_be_p1[i]) begin
                rd[i*BYTEWIDTH +: BYTEWIDTH] = snap_data_p1[i*BYTEWIDTH +: BYTEWIDTH];
            end
        end
    end

endmodule
